// File: rtl/multi_cycle_control.sv
// Multi-cycle control unit for a small RV32 subset (addi, lw, sw, bne).
// Sequences fetch/decode/execute/memory/writeback and traps on illegal opcodes or memory timeout.
module multi_cycle_control #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic [2:0]            ImmSrc,
    output logic                  MemToReg,
    output logic                  trap
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [1:0] {OP_ADDI, OP_LW, OP_SW, OP_BNE} op_t;

    localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

    state_t     state;
    op_t        op;
    logic [3:0] wait_cnt;
    logic       req_r;
    logic       fetch_done;
    logic       bne_taken;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            op       <= OP_ADDI;
            wait_cnt <= 4'd0;
            req_r    <= 1'b1;
            mem_we   <= 1'b0;
            RegWrite <= 1'b0;
            ALUsrc   <= 1'b0;
            ALUctrl  <= 3'b000;
            ImmSrc   <= 3'b000;
            MemToReg <= 1'b0;
            trap     <= 1'b0;
        end else begin
            // single-cycle strobes; the case below raises them for the state being entered
            RegWrite <= 1'b0;
            ALUsrc   <= 1'b0;
            ALUctrl  <= 3'b000;
            ImmSrc   <= 3'b000;
            MemToReg <= 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        state <= DECODE;
                        req_r <= 1'b0;
                    end else if (wait_cnt == TIMEOUT) begin
                        state <= HALT;
                        req_r <= 1'b0;
                        trap  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DECODE: begin
                    case ({instr[14:12], instr[6:0]})
                        {3'b000, 7'b0010011}: begin
                            op <= OP_ADDI; state <= EXEC; ALUsrc <= 1'b1;
                        end
                        {3'b010, 7'b0000011}: begin
                            op <= OP_LW; state <= EXEC; ALUsrc <= 1'b1;
                        end
                        {3'b010, 7'b0100011}: begin
                            op <= OP_SW; state <= EXEC; ALUsrc <= 1'b1; ImmSrc <= 3'b001;
                        end
                        {3'b001, 7'b1100011}: begin
                            op <= OP_BNE; state <= EXEC; ALUctrl <= 3'b001; ImmSrc <= 3'b010;
                        end
                        default: begin
                            state <= HALT;
                            trap  <= 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    case (op)
                        OP_ADDI: begin
                            state    <= WB;
                            RegWrite <= 1'b1;
                        end
                        OP_LW, OP_SW: begin
                            state    <= MEM;
                            req_r    <= 1'b1;
                            mem_we   <= (op == OP_SW);
                            wait_cnt <= 4'd0;
                        end
                        default: begin
                            state    <= FETCH;
                            req_r    <= 1'b1;
                            wait_cnt <= 4'd0;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (op == OP_SW) begin
                            state    <= FETCH;
                            wait_cnt <= 4'd0;
                        end else begin
                            state    <= WB;
                            req_r    <= 1'b0;
                            RegWrite <= 1'b1;
                            MemToReg <= 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT) begin
                        state  <= HALT;
                        req_r  <= 1'b0;
                        mem_we <= 1'b0;
                        trap   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WB: begin
                    state    <= FETCH;
                    req_r    <= 1'b1;
                    wait_cnt <= 4'd0;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Completion and branch strobes must follow mem_ready/EQ in the same cycle,
    // and are gated by rst so nothing fires while reset is held.
    assign mem_req    = req_r & ~rst;
    assign fetch_done = (state == FETCH) & mem_ready & ~rst;
    assign bne_taken  = (state == EXEC) & (op == OP_BNE) & ~EQ;
    assign IRWrite    = fetch_done;
    assign PCWrite    = fetch_done | bne_taken;
    assign PCsrc      = bne_taken;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-cycle expected output vectors pushed to a
// scoreboard queue when inputs are driven, popped and compared mid-cycle.
module tb_multi_cycle_control;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_ILL  = 32'h00000033;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        EQ = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, MemToReg, trap;
    logic [2:0]  ALUctrl, ImmSrc;
    logic [14:0] outv;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [14:0] sb_q[$];

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        logic        rdy;
        logic [14:0] exp;
    } vec_t;
    vec_t tbl[$];

    multi_cycle_control #(.DATA_WIDTH(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .ImmSrc(ImmSrc), .MemToReg(MemToReg), .trap(trap)
    );

    always #5 clk = ~clk;

    assign outv = {mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc,
                   ALUctrl, ImmSrc, MemToReg, trap};

    function automatic logic [14:0] o(input logic req, we, irw, pcw, pcs, rw, asrc,
                                      input logic [2:0] actl, isrc,
                                      input logic m2r, trp);
        return {req, we, irw, pcw, pcs, rw, asrc, actl, isrc, m2r, trp};
    endfunction

    logic [14:0] O_ZERO, O_FRDY, O_FWAIT, O_TRAP, O_EX_I, O_EX_S, O_BNE_T, O_BNE_N,
                 O_WB_ALU, O_WB_MEM, O_MEM_RD, O_MEM_WR;

    task automatic check(input string nm, input logic [14:0] got, input logic [14:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: outputs got %b, expected %b", nm, got, exp);
    endtask

    // One clock cycle: drive after the edge, compare the scoreboard head mid-cycle.
    task automatic step(input string nm, input logic release_rst, input logic [31:0] ins,
                        input logic eq, input logic rdy, input logic [14:0] exp);
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b0;
        instr = ins;
        EQ = eq;
        mem_ready = rdy;
        sb_q.push_back(exp);
        @(negedge clk);
        if (sb_q.size() == 0) check({nm, " sb_empty"}, outv, 15'h7fff);
        else check(nm, outv, sb_q.pop_front());
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready = 1'b1;
        EQ = 1'b0;
        #1;
        check("reset_outputs", outv, O_ZERO);
    endtask

    task automatic add(input logic [31:0] ins, input logic eq, input logic rdy,
                       input logic [14:0] exp);
        vec_t v;
        v.instr = ins; v.eq = eq; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        O_ZERO   = '0;
        O_FRDY   = o(1,0,1,1,0,0,0,3'd0,3'd0,0,0);
        O_FWAIT  = o(1,0,0,0,0,0,0,3'd0,3'd0,0,0);
        O_TRAP   = o(0,0,0,0,0,0,0,3'd0,3'd0,0,1);
        O_EX_I   = o(0,0,0,0,0,0,1,3'd0,3'd0,0,0);
        O_EX_S   = o(0,0,0,0,0,0,1,3'd0,3'd1,0,0);
        O_BNE_T  = o(0,0,0,1,1,0,0,3'd1,3'd2,0,0);
        O_BNE_N  = o(0,0,0,0,0,0,0,3'd1,3'd2,0,0);
        O_WB_ALU = o(0,0,0,0,0,1,0,3'd0,3'd0,0,0);
        O_WB_MEM = o(0,0,0,0,0,1,0,3'd0,3'd0,1,0);
        O_MEM_RD = o(1,0,0,0,0,0,0,3'd0,3'd0,0,0);
        O_MEM_WR = o(1,1,0,0,0,0,0,3'd0,3'd0,0,0);

        // addi, zero-wait: FETCH DECODE EXEC WB
        add(I_ADDI,1,1,O_FRDY); add(I_ADDI,0,0,O_ZERO); add(I_ADDI,0,0,O_EX_I); add(I_ADDI,0,1,O_WB_ALU);
        // bne taken / not taken
        add(I_BNE,1,1,O_FRDY); add(I_BNE,1,0,O_ZERO); add(I_BNE,0,0,O_BNE_T);
        add(I_BNE,0,1,O_FRDY); add(I_BNE,0,0,O_ZERO); add(I_BNE,1,1,O_BNE_N);
        // sw, zero-wait
        add(I_SW,1,1,O_FRDY); add(I_SW,0,0,O_ZERO); add(I_SW,0,0,O_EX_S); add(I_SW,0,1,O_MEM_WR);
        // lw with mem_ready delayed 3 cycles in MEM: 8 cycles total
        add(I_LW,0,1,O_FRDY); add(I_LW,0,0,O_ZERO); add(I_LW,0,0,O_EX_I);
        add(I_LW,0,0,O_MEM_RD); add(I_LW,1,0,O_MEM_RD); add(I_LW,0,0,O_MEM_RD); add(I_LW,0,1,O_MEM_RD);
        add(I_LW,0,0,O_WB_MEM);
        // addi with a slow fetch, then back to a waiting FETCH
        add(I_ADDI,0,0,O_FWAIT); add(I_ADDI,0,0,O_FWAIT); add(I_ADDI,0,1,O_FRDY);
        add(I_ADDI,0,0,O_ZERO); add(I_ADDI,0,0,O_EX_I); add(I_ADDI,0,0,O_WB_ALU);
        add(I_ADDI,0,0,O_FWAIT);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outv, O_ZERO);
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), i == 0, tbl[i].instr, tbl[i].eq, tbl[i].rdy, tbl[i].exp);

        // fetch timeout: 16 FETCH cycles (counter 0..15) without mem_ready, then HALT
        apply_reset();
        step("timeout_c0", 1'b1, I_ADDI, 0, 0, O_FWAIT);
        for (int k = 1; k <= 15; k++) step($sformatf("timeout_c%0d", k), 1'b0, I_ADDI, 0, 0, O_FWAIT);
        for (int k = 0; k < 3; k++) step($sformatf("halt_hold%0d", k), 1'b0, I_BNE, 0, 1, O_TRAP);

        // mem_ready arrives in the cycle the counter reaches the limit: no trap
        apply_reset();
        step("edge_c0", 1'b1, I_ADDI, 0, 0, O_FWAIT);
        for (int k = 1; k <= 14; k++) step($sformatf("edge_c%0d", k), 1'b0, I_ADDI, 0, 0, O_FWAIT);
        step("edge_ready", 1'b0, I_ADDI, 0, 1, O_FRDY);
        step("edge_decode", 1'b0, I_ADDI, 0, 0, O_ZERO);
        step("edge_exec", 1'b0, I_ADDI, 0, 0, O_EX_I);

        // unsupported R-type
        apply_reset();
        step("ill_fetch", 1'b1, I_ILL, 0, 1, O_FRDY);
        step("ill_decode", 1'b0, I_ILL, 0, 1, O_ZERO);
        step("ill_halt0", 1'b0, I_ILL, 0, 1, O_TRAP);
        step("ill_halt1", 1'b0, I_ADDI, 1, 1, O_TRAP);

        // reset pulsed in the MEM phase of sw
        apply_reset();
        step("swr_fetch", 1'b1, I_SW, 0, 1, O_FRDY);
        step("swr_decode", 1'b0, I_SW, 0, 0, O_ZERO);
        step("swr_exec", 1'b0, I_SW, 0, 0, O_EX_S);
        step("swr_mem", 1'b0, I_SW, 0, 0, O_MEM_WR);
        #2;
        rst = 1'b1;
        #1;
        check("swr_rst_drop", outv, O_ZERO);
        step("swr_refetch", 1'b1, I_ADDI, 0, 1, O_FRDY);
        step("swr_redecode", 1'b0, I_ADDI, 0, 0, O_ZERO);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
